// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller:
// FSM state codes, the x0 register index and the debug reason codes.
package pipeline_ctrl_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RSN_NONE     = 2'd0,
        RSN_MEM      = 2'd1,
        RSN_BRANCH   = 2'd2,
        RSN_LOAD_USE = 2'd3
    } reason_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Data-memory request/acknowledge handshake between the pipeline controller
// (master) and the data memory (slave).
interface pipeline_ctrl_if;
    logic dmem_req;
    logic dmem_ack;

    modport master (output dmem_req, input dmem_ack);
    modport slave  (input dmem_req, output dmem_ack);
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: the instruction in ID reads the destination of a
// load still in EX. Kept standalone so the forwarding unit can reuse it.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    // x0 never carries a real dependency, so a load targeting it cannot stall
    assign load_use = ex_mem_read & (ex_rd != REG_X0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) |
                       (id_rs2_used & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes from memory wait
// states, taken branches and load-use hazards, plus a memory watchdog and counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           IFID_rs1,
    input  logic [4:0]           IFID_rs2,
    input  logic                 IFID_rs1_used,
    input  logic                 IFID_rs2_used,
    input  logic                 IDEX_MemRead,
    input  logic [4:0]           IDEX_rd,
    input  logic                 EX_BranchTaken,
    input  logic                 EXMEM_MemRead,
    input  logic                 EXMEM_MemWrite,
    pipeline_ctrl_if.master      dmem,
    output logic                 PC_En,
    output logic                 IFID_En,
    output logic                 IDEX_En,
    output logic                 EXMEM_En,
    output logic                 MEMWB_En,
    output logic                 IFID_Flush,
    output logic                 IDEX_Flush,
    output logic                 MEMWB_Flush,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    logic [0:0]       state_r, state_nxt_s;
    logic [WCW-1:0]   wait_cnt_r, wait_cnt_nxt_s;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cycles_r, flush_count_r;
    logic             mem_access_s, req_s, timeout_hit_s, mem_stall_s, load_use_s;
    reason_e          reason_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            sat_inc = v + CNT_W'(1'b1);
        end else begin
            sat_inc = v;
        end
    endfunction

    hazard_detect u_hazard_detect (
        .id_rs1      (IFID_rs1),
        .id_rs2      (IFID_rs2),
        .id_rs1_used (IFID_rs1_used),
        .id_rs2_used (IFID_rs2_used),
        .ex_mem_read (IDEX_MemRead),
        .ex_rd       (IDEX_rd),
        .load_use    (load_use_s)
    );

    assign mem_access_s  = EXMEM_MemRead | EXMEM_MemWrite;
    assign req_s         = (state_r == ST_MEM_WAIT) | mem_access_s;
    // On the timeout cycle the request is still up but the pipeline is released
    assign timeout_hit_s = (state_r == ST_MEM_WAIT) & (wait_cnt_r == WCW'(MEM_TIMEOUT)) & ~dmem.dmem_ack;
    assign mem_stall_s   = req_s & ~dmem.dmem_ack & ~timeout_hit_s;

    // Stall source priority: memory freeze, then branch redirect, then load-use
    always_comb begin
        if (mem_stall_s) begin
            reason_s = RSN_MEM;
        end else if (EX_BranchTaken) begin
            reason_s = RSN_BRANCH;
        end else if (load_use_s) begin
            reason_s = RSN_LOAD_USE;
        end else begin
            reason_s = RSN_NONE;
        end
    end

    // Wait-state FSM and watchdog next-state
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_access_s & ~dmem.dmem_ack) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = WCW'(1);
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem.dmem_ack | timeout_hit_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + WCW'(1);
                end
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = {WCW{1'b0}};
            end
        endcase
    end

    // Stage enables/flushes; reset forces every stage to load a bubble
    always_comb begin
        dmem.dmem_req = 1'b0;
        {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b00000;
        {IFID_Flush, IDEX_Flush, MEMWB_Flush}         = 3'b111;
        if (rst_n) begin
            dmem.dmem_req = req_s;
            case (reason_s)
                RSN_MEM: begin
                    {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b00001;
                    {IFID_Flush, IDEX_Flush, MEMWB_Flush}         = 3'b001;
                end
                RSN_BRANCH: begin
                    {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b11111;
                    {IFID_Flush, IDEX_Flush, MEMWB_Flush}         = 3'b110;
                end
                RSN_LOAD_USE: begin
                    {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b00111;
                    {IFID_Flush, IDEX_Flush, MEMWB_Flush}         = 3'b010;
                end
                default: begin
                    {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b11111;
                    {IFID_Flush, IDEX_Flush, MEMWB_Flush}         = 3'b000;
                end
            endcase
        end else begin
            dmem.dmem_req = 1'b0;
        end
    end

    // State, watchdog, sticky error and saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_RUN;
            wait_cnt_r     <= {WCW{1'b0}};
            mem_err_r      <= 1'b0;
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            wait_cnt_r     <= wait_cnt_nxt_s;
            mem_err_r      <= mem_err_r | timeout_hit_s;
            stall_cycles_r <= sat_inc(stall_cycles_r,
                                      (reason_s == RSN_MEM) | (reason_s == RSN_LOAD_USE));
            flush_count_r  <= sat_inc(flush_count_r, reason_s == RSN_BRANCH);
        end
    end

    assign mem_err      = mem_err_r;
    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_pipeline_ctrl;

    localparam int TO  = 4;
    localparam int CW  = 16;
    localparam int CWS = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, idex_rd;
    logic u1, u2, idex_mr, br, emr, emw, ack;

    always #5 clk = ~clk;

    pipeline_ctrl_if mif ();
    pipeline_ctrl_if mif_s ();
    assign mif.dmem_ack   = ack;
    assign mif_s.dmem_ack = ack;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl, mem_err;
    logic [CW-1:0] stall_cycles, flush_count;
    logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_fl, s_idex_fl, s_memwb_fl, s_mem_err;
    logic [CWS-1:0] s_stall_cycles, s_flush_count;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_rs1_used(u1), .IFID_rs2_used(u2),
        .IDEX_MemRead(idex_mr), .IDEX_rd(idex_rd), .EX_BranchTaken(br),
        .EXMEM_MemRead(emr), .EXMEM_MemWrite(emw), .dmem(mif),
        .PC_En(pc_en), .IFID_En(ifid_en), .IDEX_En(idex_en), .EXMEM_En(exmem_en), .MEMWB_En(memwb_en),
        .IFID_Flush(ifid_fl), .IDEX_Flush(idex_fl), .MEMWB_Flush(memwb_fl),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_rs1_used(u1), .IFID_rs2_used(u2),
        .IDEX_MemRead(idex_mr), .IDEX_rd(idex_rd), .EX_BranchTaken(br),
        .EXMEM_MemRead(emr), .EXMEM_MemWrite(emw), .dmem(mif_s),
        .PC_En(s_pc_en), .IFID_En(s_ifid_en), .IDEX_En(s_idex_en), .EXMEM_En(s_exmem_en), .MEMWB_En(s_memwb_en),
        .IFID_Flush(s_ifid_fl), .IDEX_Flush(s_idex_fl), .MEMWB_Flush(s_memwb_fl),
        .mem_err(s_mem_err), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: pending request age, sticky error, unbounded event counts
    bit m_wait;
    int m_age;
    bit m_err;
    int m_stalls;
    int m_flushes;
    logic [8:0] last_act;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, mr, br, emr, emw, ack;
        logic [8:0] exp;   // {req, PC,IFID,IDEX,EXMEM,MEMWB En, IFID,IDEX,MEMWB Flush}
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0; idex_mr = 1'b0; idex_rd = 5'd0;
        br = 1'b0; emr = 1'b0; emw = 1'b0; ack = 1'b0;
    endtask

    // One clock: sample outputs, compare against the model (and a table entry), advance
    task automatic cycle(input bit use_tab, input logic [8:0] tab);
        logic [8:0] exp, act;
        bit acc, req, tmo, ms, lu;
        #1;
        if (!rst_n) begin
            m_wait = 1'b0; m_age = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
        end
        acc = emr | emw;
        req = rst_n && (m_wait || acc);
        tmo = m_wait && (m_age == TO) && !ack;
        ms  = req && !ack && !tmo;
        lu  = idex_mr && (idex_rd != 5'd0) && ((u1 && rs1 == idex_rd) || (u2 && rs2 == idex_rd));
        if (!rst_n)   exp = 9'b0_00000_111;
        else if (ms)  exp = 9'b1_00001_001;
        else if (br)  exp = {req, 8'b11111_110};
        else if (lu)  exp = {req, 8'b00111_010};
        else          exp = {req, 8'b11111_000};
        act = {mif.dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl};
        last_act = act;
        check("ctrl", 32'(act), 32'(exp));
        if (use_tab) check("table", 32'(act), 32'(tab));
        check("mem_err", 32'(mem_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), sat(m_stalls, CW));
        check("flush_count", 32'(flush_count), sat(m_flushes, CW));
        check("sat_stall", 32'(s_stall_cycles), sat(m_stalls, CWS));
        check("sat_flush", 32'(s_flush_count), sat(m_flushes, CWS));
        if (rst_n) begin
            if (ms || (!br && lu)) m_stalls++;
            if (!ms && br) m_flushes++;
            if (req) begin
                if (ack || tmo) begin
                    m_wait = 1'b0; m_age = 0;
                    if (tmo) m_err = 1'b1;
                end else begin
                    m_wait = 1'b1; m_age++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[9];
    int nreq, nfrz;
    logic [CW-1:0] st0, fl0;

    initial begin
        vecs[0] = '{rs1:5'd5, rs2:5'd0, rd:5'd5, u1:1'b1, u2:1'b0, mr:1'b1, br:1'b0, emr:1'b0, emw:1'b0, ack:1'b0, exp:9'b0_00111_010};
        vecs[1] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:1'b1, u2:1'b0, mr:1'b1, br:1'b0, emr:1'b0, emw:1'b0, ack:1'b0, exp:9'b0_11111_000};
        vecs[2] = '{rs1:5'd3, rs2:5'd7, rd:5'd7, u1:1'b1, u2:1'b1, mr:1'b1, br:1'b0, emr:1'b0, emw:1'b0, ack:1'b0, exp:9'b0_00111_010};
        vecs[3] = '{rs1:5'd9, rs2:5'd1, rd:5'd9, u1:1'b0, u2:1'b1, mr:1'b1, br:1'b0, emr:1'b0, emw:1'b0, ack:1'b0, exp:9'b0_11111_000};
        vecs[4] = '{rs1:5'd5, rs2:5'd0, rd:5'd5, u1:1'b1, u2:1'b0, mr:1'b0, br:1'b0, emr:1'b0, emw:1'b0, ack:1'b0, exp:9'b0_11111_000};
        vecs[5] = '{rs1:5'd5, rs2:5'd0, rd:5'd5, u1:1'b1, u2:1'b0, mr:1'b1, br:1'b1, emr:1'b0, emw:1'b0, ack:1'b0, exp:9'b0_11111_110};
        vecs[6] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:1'b0, u2:1'b0, mr:1'b0, br:1'b0, emr:1'b0, emw:1'b1, ack:1'b1, exp:9'b1_11111_000};
        vecs[7] = '{rs1:5'd2, rs2:5'd0, rd:5'd2, u1:1'b1, u2:1'b0, mr:1'b1, br:1'b0, emr:1'b1, emw:1'b0, ack:1'b1, exp:9'b1_00111_010};
        vecs[8] = '{rs1:5'd0, rs2:5'd0, rd:5'd0, u1:1'b0, u2:1'b0, mr:1'b0, br:1'b0, emr:1'b0, emw:1'b0, ack:1'b1, exp:9'b0_11111_000};

        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        cycle(1'b1, 9'b0_00000_111);
        cycle(1'b1, 9'b0_00000_111);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; idex_rd = vecs[i].rd;
            u1 = vecs[i].u1; u2 = vecs[i].u2; idex_mr = vecs[i].mr; br = vecs[i].br;
            emr = vecs[i].emr; emw = vecs[i].emw; ack = vecs[i].ack;
            cycle(1'b1, vecs[i].exp);
        end
        set_idle();
        cycle(1'b0, 9'b0);

        // Load in MEM, ack on the 4th request cycle: 3 freeze cycles
        st0 = stall_cycles; nreq = 0; nfrz = 0;
        emr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ack = (k == 3);
            cycle(1'b0, 9'b0);
            nreq += int'(last_act[8]);
            nfrz += int'(last_act[0]);
        end
        set_idle();
        cycle(1'b0, 9'b0);
        check("wait_req_cycles", nreq, 4);
        check("wait_freeze_cycles", nfrz, 3);
        check("wait_stall_delta", 32'(stall_cycles - st0), 3);

        // Branch and load-use held behind a memory freeze, branch lands on release
        fl0 = flush_count;
        emr = 1'b1; br = 1'b1; idex_mr = 1'b1; idex_rd = 5'd6; rs1 = 5'd6; u1 = 1'b1;
        cycle(1'b0, 9'b0);
        cycle(1'b0, 9'b0);
        ack = 1'b1;
        cycle(1'b0, 9'b0);
        check("branch_after_freeze", 32'(last_act), 32'(9'b1_11111_110));
        set_idle();
        cycle(1'b0, 9'b0);
        check("branch_flush_delta", 32'(flush_count - fl0), 1);

        // Watchdog: ack never arrives
        st0 = stall_cycles;
        emr = 1'b1;
        for (int k = 0; k < 5; k++) cycle(1'b0, 9'b0);
        check("timeout_release", 32'(last_act), 32'(9'b1_11111_000));
        set_idle();
        cycle(1'b0, 9'b0);
        check("timeout_err", 32'(mem_err), 1);
        check("timeout_stall_delta", 32'(stall_cycles - st0), 4);
        for (int k = 0; k < 3; k++) cycle(1'b0, 9'b0);
        check("err_sticky", 32'(mem_err), 1);

        // Reset while waiting on memory
        emr = 1'b1;
        cycle(1'b0, 9'b0);
        cycle(1'b0, 9'b0);
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", 32'(mif.dmem_req), 0);
        check("rst_err_clear", 32'(mem_err), 0);
        check("rst_cnt_clear", 32'(stall_cycles), 0);
        set_idle();
        cycle(1'b0, 9'b0);
        rst_n = 1'b1;
        emw = 1'b1; ack = 1'b1;
        cycle(1'b0, 9'b0);
        check("rst_resume_run", 32'(last_act), 32'(9'b1_11111_000));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n   = ($urandom_range(0, 63) != 0);
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            idex_rd = 5'($urandom_range(0, 3));
            u1      = 1'($urandom_range(0, 1));
            u2      = 1'($urandom_range(0, 1));
            idex_mr = 1'($urandom_range(0, 1));
            br      = ($urandom_range(0, 7) == 0);
            emr     = ($urandom_range(0, 3) == 0);
            emw     = ($urandom_range(0, 5) == 0);
            ack     = ($urandom_range(0, 2) == 0);
            cycle(1'b0, 9'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
